// File: rtl/synchronous_packet_fifo.sv
// -----------------------------------------------------------------------------
// synchronous_packet_fifo
//
// Packet-aware single-clock FIFO with store-and-forward semantics. Words of a
// packet are written at a tentative pointer and only become readable once the
// packet's last word is committed. The writer may discard the packet in
// progress (write_drop). A packet that hits a full FIFO is poisoned and is
// discarded automatically when its last word arrives.
//
// Each storage word holds DATA_WIDTH data bits plus a last flag. There are
// three pointers, each carrying one extra wrap bit:
//   rd_ptr  - next word to pop
//   cm_ptr  - end of the committed region (reader sees rd_ptr..cm_ptr)
//   tw_ptr  - tentative write pointer (end of the packet being written)
//
// Optional feature macro: SYNCHRONOUS_PACKET_FIFO_STATS_EN
//   When defined, adds dropped_packet_count (16 bit, saturating), counting
//   explicit drops of a non-empty partial packet and poisoned auto-drops.
//
// Handshake semantics:
//   Write side: a word is accepted on a rising edge where write_enable=1,
//   write_drop=0 and full=0. write_drop has priority over write_enable. A
//   write attempted while full is not accepted, pulses overflow and poisons
//   the packet. There is no back-pressure beyond the full flag.
//   Read side: a word is popped on a rising edge where read_enable=1 and
//   empty=0. In standard mode the popped word appears on read_data with
//   read_data_valid=1 the following cycle. In FWFT mode the head word is
//   always presented with read_data_valid=!empty and read_enable acts as the
//   acknowledge. read_enable while empty pops nothing and pulses underflow.
//
// Ports:
//   clock                 in   rising-edge clock
//   reset_n               in   synchronous active-low reset
//   write_enable          in   write write_data this cycle
//   write_data            in   [DATA_WIDTH] write word
//   write_last            in   word ends the packet, commit it
//   write_drop            in   discard the packet currently being written
//   read_enable           in   pop request
//   read_data             out  [DATA_WIDTH] read word
//   read_data_valid       out  read_data holds a valid word
//   read_last             out  read_data is the last word of its packet
//   full                  out  no free word (tentative vs read pointer)
//   empty                 out  no committed word available
//   almost_full           out  used_count >= ALMOST_FULL_THRESHOLD
//   almost_empty          out  committed words <= ALMOST_EMPTY_THRESHOLD
//   used_count            out  committed plus uncommitted words held
//   packet_count          out  committed packets not yet fully read
//   overflow              out  one-cycle pulse, write attempted while full
//   underflow             out  one-cycle pulse, read attempted while empty
//   dropped_packet_count  out  [16] (stats build only) dropped packets
// -----------------------------------------------------------------------------
module synchronous_packet_fifo #(
    parameter int DATA_WIDTH             = 16,
    parameter int DATA_DEPTH             = 4096,
    parameter int FIRST_WORD_FALL_THROUGH = 0,
    parameter int ALMOST_FULL_THRESHOLD  = DATA_DEPTH - 4,
    parameter int ALMOST_EMPTY_THRESHOLD = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          write_enable,
    input  logic [DATA_WIDTH-1:0]         write_data,
    input  logic                          write_last,
    input  logic                          write_drop,
    input  logic                          read_enable,
    output logic [DATA_WIDTH-1:0]         read_data,
    output logic                          read_data_valid,
    output logic                          read_last,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(DATA_DEPTH):0]   used_count,
    output logic [$clog2(DATA_DEPTH):0]   packet_count,
    output logic                          overflow,
    output logic                          underflow
`ifdef SYNCHRONOUS_PACKET_FIFO_STATS_EN
    ,
    output logic [15:0]                   dropped_packet_count
`endif
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    // Storage: {last, data} per word.
    logic [DATA_WIDTH:0] mem [DATA_DEPTH];

    ptr_t rd_ptr;
    ptr_t cm_ptr;
    ptr_t tw_ptr;
    ptr_t rd_next;
    ptr_t committed_count;
    logic poisoned;

    logic write_attempt;
    logic write_fire;
    logic commit;
    logic auto_drop;
    logic pop;
    logic head_last;
    logic pop_last;

    // -------------------------------------------------------------------------
    // Occupancy and flags. All derived combinationally from the pointers, so a
    // commit on edge N is visible to the reader from edge N onwards.
    // -------------------------------------------------------------------------
    always_comb begin
        used_count      = tw_ptr - rd_ptr;
        committed_count = cm_ptr - rd_ptr;
        full            = (used_count == PW'(DATA_DEPTH));
        empty           = (committed_count == '0);
        almost_full     = (used_count >= PW'(ALMOST_FULL_THRESHOLD));
        almost_empty    = (committed_count <= PW'(ALMOST_EMPTY_THRESHOLD));
    end

    // -------------------------------------------------------------------------
    // Write / read decode.
    //   full is taken from the pointers before this edge, so a pop in the same
    //   cycle never makes room for a write.
    //   A last word that is poisoned, or that itself overflows, ends the packet
    //   by discarding it rather than committing it.
    // -------------------------------------------------------------------------
    always_comb begin
        write_attempt = write_enable && !write_drop;
        write_fire    = write_attempt && !full;
        auto_drop     = write_attempt && write_last && (poisoned || full);
        commit        = write_fire && write_last && !poisoned;
        pop           = read_enable && !empty;
        pop_last      = pop && head_last;
        rd_next       = pop ? (rd_ptr + PW'(1)) : rd_ptr;
    end

    // Storage array carries no reset; only pointers define what is valid.
    always_ff @(posedge clock) begin
        if (write_fire) begin
            mem[tw_ptr[AW-1:0]] <= {write_last, write_data};
        end
    end

    // -------------------------------------------------------------------------
    // Pointer, poison, count and pulse registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr       <= '0;
            cm_ptr       <= '0;
            tw_ptr       <= '0;
            poisoned     <= 1'b0;
            packet_count <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            rd_ptr <= rd_next;

            if (write_drop || auto_drop) begin
                // Rewind the tentative pointer; the partial packet vanishes.
                tw_ptr   <= cm_ptr;
                poisoned <= 1'b0;
            end else if (write_fire) begin
                tw_ptr <= tw_ptr + PW'(1);
                if (commit) begin
                    cm_ptr <= tw_ptr + PW'(1);
                end
            end else if (write_attempt && full) begin
                poisoned <= 1'b1;
            end

            // Commit and pop of a last word on the same edge cancel out.
            case ({commit, pop_last})
                2'b10:   packet_count <= packet_count + PW'(1);
                2'b01:   packet_count <= packet_count - PW'(1);
                default: packet_count <= packet_count;
            endcase

            overflow  <= write_attempt && full;
            underflow <= read_enable && empty;
        end
    end

`ifdef SYNCHRONOUS_PACKET_FIFO_STATS_EN
    // -------------------------------------------------------------------------
    // Dropped-packet statistics. An explicit drop only counts when there was
    // actually a partial packet to throw away.
    // -------------------------------------------------------------------------
    logic drop_event;

    always_comb begin
        drop_event = (write_drop && (tw_ptr != cm_ptr)) || auto_drop;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dropped_packet_count <= '0;
        end else if (drop_event && (dropped_packet_count != 16'hFFFF)) begin
            dropped_packet_count <= dropped_packet_count + 16'd1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Read path.
    // -------------------------------------------------------------------------
    generate
        if (FIRST_WORD_FALL_THROUGH != 0) begin : g_fwft
            // Prefetch register always holds the word at the read pointer
            // that will be current after this edge. When that word is being
            // written on this very edge it is taken from the write bus, since
            // the array does not hold it yet. Words captured that way but
            // later dropped stay invisible because empty gates validity.
            logic [DATA_WIDTH:0] head_q;

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    head_q <= '0;
                end else if (write_fire && (tw_ptr == rd_next)) begin
                    head_q <= {write_last, write_data};
                end else begin
                    head_q <= mem[rd_next[AW-1:0]];
                end
            end

            assign head_last       = head_q[DATA_WIDTH];
            assign read_data       = head_q[DATA_WIDTH-1:0];
            assign read_last       = head_q[DATA_WIDTH];
            assign read_data_valid = !empty;
        end else begin : g_std
            logic [DATA_WIDTH:0] head_word;

            assign head_word = mem[rd_ptr[AW-1:0]];
            assign head_last = head_word[DATA_WIDTH];

            // read_data / read_last hold their last value between pops.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    read_data       <= '0;
                    read_last       <= 1'b0;
                    read_data_valid <= 1'b0;
                end else begin
                    read_data_valid <= pop;
                    if (pop) begin
                        read_data <= head_word[DATA_WIDTH-1:0];
                        read_last <= head_word[DATA_WIDTH];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_synchronous_packet_fifo.sv
// -----------------------------------------------------------------------------
// tb_synchronous_packet_fifo
//
// Drives one standard-mode and one FWFT-mode instance (DEPTH=8, WIDTH=16)
// from the same input signals. Because popping and writing are decided the
// same way in both modes, one packet-level reference model predicts both.
// The model keeps a queue of committed words and a queue of words belonging
// to the packet still being written; counts and flags are derived from the
// queue sizes.
// -----------------------------------------------------------------------------
module tb_synchronous_packet_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    logic          write_enable = 1'b0;
    logic [DW-1:0] write_data   = '0;
    logic          write_last   = 1'b0;
    logic          write_drop   = 1'b0;
    logic          read_enable  = 1'b0;

    logic [DW-1:0] s_read_data, f_read_data;
    logic          s_read_data_valid, f_read_data_valid;
    logic          s_read_last, f_read_last;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_almost_full, f_almost_full, s_almost_empty, f_almost_empty;
    logic [CW-1:0] s_used_count, f_used_count, s_packet_count, f_packet_count;
    logic          s_overflow, f_overflow, s_underflow, f_underflow;
`ifdef SYNCHRONOUS_PACKET_FIFO_STATS_EN
    logic [15:0]   s_dropped, f_dropped;
`endif

    synchronous_packet_fifo #(
        .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FIRST_WORD_FALL_THROUGH(0)
    ) dut_std (
        .clock(clock), .reset_n(reset_n),
        .write_enable(write_enable), .write_data(write_data),
        .write_last(write_last), .write_drop(write_drop),
        .read_enable(read_enable),
        .read_data(s_read_data), .read_data_valid(s_read_data_valid),
        .read_last(s_read_last), .full(s_full), .empty(s_empty),
        .almost_full(s_almost_full), .almost_empty(s_almost_empty),
        .used_count(s_used_count), .packet_count(s_packet_count),
        .overflow(s_overflow), .underflow(s_underflow)
`ifdef SYNCHRONOUS_PACKET_FIFO_STATS_EN
        , .dropped_packet_count(s_dropped)
`endif
    );

    synchronous_packet_fifo #(
        .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FIRST_WORD_FALL_THROUGH(1)
    ) dut_fwft (
        .clock(clock), .reset_n(reset_n),
        .write_enable(write_enable), .write_data(write_data),
        .write_last(write_last), .write_drop(write_drop),
        .read_enable(read_enable),
        .read_data(f_read_data), .read_data_valid(f_read_data_valid),
        .read_last(f_read_last), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .used_count(f_used_count), .packet_count(f_packet_count),
        .overflow(f_overflow), .underflow(f_underflow)
`ifdef SYNCHRONOUS_PACKET_FIFO_STATS_EN
        , .dropped_packet_count(f_dropped)
`endif
    );

    // ---------------- scoreboard / reference model ----------------
    logic [DW:0]   exp_q[$];   // committed, unread words {last, data}
    logic [DW:0]   pend_q[$];  // words of the packet being written
    bit            m_poisoned;
    int            m_drops;
    logic [DW-1:0] m_rdata;
    bit            m_rlast, m_rvalid, m_ovf, m_udf;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int  used;
        bit  m_full;
        bit  m_empty;
        logic [DW:0] w;
        if (!reset_n) begin
            exp_q.delete(); pend_q.delete();
            m_poisoned = 0; m_drops = 0;
            m_rdata = '0; m_rlast = 0; m_rvalid = 0; m_ovf = 0; m_udf = 0;
            return;
        end
        used    = exp_q.size() + pend_q.size();
        m_full  = (used == DEPTH);
        m_empty = (exp_q.size() == 0);
        m_udf    = read_enable && m_empty;
        m_rvalid = read_enable && !m_empty;
        if (m_rvalid) begin
            w = exp_q.pop_front();
            m_rdata = w[DW-1:0];
            m_rlast = w[DW];
        end
        m_ovf = 0;
        if (write_drop) begin
            if (pend_q.size() > 0 && m_drops < 65535) m_drops++;
            pend_q.delete();
            m_poisoned = 0;
        end else if (write_enable) begin
            if (m_full) begin
                m_ovf = 1;
                if (write_last) begin
                    if (m_drops < 65535) m_drops++;
                    pend_q.delete();
                    m_poisoned = 0;
                end else begin
                    m_poisoned = 1;
                end
            end else if (write_last && m_poisoned) begin
                if (m_drops < 65535) m_drops++;
                pend_q.delete();
                m_poisoned = 0;
            end else begin
                pend_q.push_back({write_last, write_data});
                if (write_last) begin
                    foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
                    pend_q.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        int used;
        int pk;
        int cc;
        logic [DW:0] h;
        used = exp_q.size() + pend_q.size();
        cc   = exp_q.size();
        pk   = 0;
        foreach (exp_q[i]) if (exp_q[i][DW]) pk++;
        check("s_used", s_used_count, used);
        check("s_pkt", s_packet_count, pk);
        check("s_empty", s_empty, cc == 0);
        check("s_full", s_full, used == DEPTH);
        check("s_afull", s_almost_full, used >= DEPTH - 4);
        check("s_aempty", s_almost_empty, cc <= 4);
        check("s_ovf", s_overflow, m_ovf);
        check("s_udf", s_underflow, m_udf);
        check("s_rvalid", s_read_data_valid, m_rvalid);
        check("s_rdata", s_read_data, m_rdata);
        check("s_rlast", s_read_last, m_rlast);
        check("f_used", f_used_count, used);
        check("f_pkt", f_packet_count, pk);
        check("f_full", f_full, used == DEPTH);
        check("f_ovf", f_overflow, m_ovf);
        check("f_udf", f_underflow, m_udf);
        check("f_rvalid", f_read_data_valid, cc != 0);
        if (cc != 0) begin
            h = exp_q[0];
            check("f_rdata", f_read_data, h[DW-1:0]);
            check("f_rlast", f_read_last, h[DW]);
        end
`ifdef SYNCHRONOUS_PACKET_FIFO_STATS_EN
        check("s_drops", s_dropped, m_drops);
        check("f_drops", f_dropped, m_drops);
`endif
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit we, input logic [DW-1:0] wd, input bit wl,
                        input bit wdrop, input bit re, input bit rst_n = 1'b1);
        write_enable = we;
        write_data   = wd;
        write_last   = wl;
        write_drop   = wdrop;
        read_enable  = re;
        reset_n      = rst_n;
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            we;
        logic [DW-1:0] wd;
        bit            wl;
        bit            wdrop;
        bit            re;
        int            e_used;
        int            e_pkt;
        bit            e_empty;
        bit            e_rvalid;
        logic [DW-1:0] e_rdata;
        bit            e_rlast;
        bit            e_udf;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit saw_full;

        // Commit visibility: A1, A2, A3(last), then three reads and an
        // underflow attempt.
        vecs[0] = '{1'b1, 16'hA1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'hA2, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1, 1'b0, 16'h0,  1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'hA3, 1'b1, 1'b0, 1'b0, 3, 1, 1'b0, 1'b0, 16'h0,  1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h0,  1'b0, 1'b0, 1'b1, 2, 1, 1'b0, 1'b1, 16'hA1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'h0,  1'b0, 1'b0, 1'b1, 1, 1, 1'b0, 1'b1, 16'hA2, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'h0,  1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 16'hA3, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h0,  1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 16'hA3, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h0,  1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 16'hA3, 1'b1, 1'b1};

        // Reset state.
        step(0, '0, 0, 0, 0, 1'b0);
        step(0, '0, 0, 0, 0, 1'b0);
        check("rst_empty", s_empty, 1);
        check("rst_aempty", s_almost_empty, 1);
        check("rst_used", s_used_count, 0);
        check("rst_rdata", s_read_data, 0);

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].we, vecs[i].wd, vecs[i].wl, vecs[i].wdrop, vecs[i].re);
            check("tbl_used", s_used_count, vecs[i].e_used);
            check("tbl_pkt", s_packet_count, vecs[i].e_pkt);
            check("tbl_empty", s_empty, vecs[i].e_empty);
            check("tbl_rvalid", s_read_data_valid, vecs[i].e_rvalid);
            check("tbl_rdata", s_read_data, vecs[i].e_rdata);
            check("tbl_rlast", s_read_last, vecs[i].e_rlast);
            check("tbl_udf", s_underflow, vecs[i].e_udf);
        end

        // Drop of a partial packet, then a fresh one-word packet.
        step(1, 16'h10, 0, 0, 0);
        step(1, 16'h11, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        check("drop_used", s_used_count, 0);
        check("drop_empty", s_empty, 1);
`ifdef SYNCHRONOUS_PACKET_FIFO_STATS_EN
        check("drop_stats", s_dropped, 1);
`endif
        step(1, 16'h20, 1, 0, 0);
        step(0, '0, 0, 0, 1);
        check("drop_rdata", s_read_data, 16'h20);
        check("drop_rlast", s_read_last, 1);

        // Overflow poison: 9 words, last on the 9th.
        for (int i = 0; i < 9; i++) begin
            step(1, 16'(16'h30 + i), (i == 8), 0, 0);
            if (i == 7) begin
                check("ovf_full8", s_full, 1);
                check("ovf_none8", s_overflow, 0);
            end
        end
        check("ovf_pulse", s_overflow, 1);
        check("ovf_used", s_used_count, 0);
        check("ovf_empty", s_empty, 1);
        step(0, '0, 0, 0, 0);
        check("ovf_clear", s_overflow, 0);
`ifdef SYNCHRONOUS_PACKET_FIFO_STATS_EN
        check("ovf_stats", s_dropped, 2);
`endif

        // Wrap-around: 5 packets of 3 words, each drained before the next.
        saw_full = 0;
        for (int p = 0; p < 5; p++) begin
            for (int w = 0; w < 3; w++) begin
                step(1, 16'(p * 256 + w + 16'h0C00), (w == 2), 0, 0);
                saw_full |= s_full;
            end
            for (int w = 0; w < 3; w++) begin
                step(0, '0, 0, 0, 1);
                check("wrap_data", s_read_data, 16'(p * 256 + w + 16'h0C00));
                check("wrap_last", s_read_last, (w == 2));
            end
        end
        check("wrap_nofull", saw_full, 0);

        // FWFT presentation before any read_enable.
        step(1, 16'hBEEF, 1, 0, 0);
        check("fwft_valid", f_read_data_valid, 1);
        check("fwft_data", f_read_data, 16'hBEEF);
        check("fwft_last", f_read_last, 1);
        step(0, '0, 0, 0, 1);
        check("fwft_popped", f_read_data_valid, 0);
        check("std_beef", s_read_data, 16'hBEEF);
        step(0, '0, 0, 0, 1);
        check("fwft_udf", f_underflow, 1);

        // Reset in the middle of a packet.
        step(1, 16'h01, 0, 0, 0);
        step(1, 16'h02, 0, 0, 0);
        step(0, '0, 0, 0, 0, 1'b0);
        check("mrst_used", s_used_count, 0);
        check("mrst_pkt", s_packet_count, 0);
        check("mrst_empty", s_empty, 1);
        step(1, 16'h55, 0, 0, 0);
        step(1, 16'h66, 1, 0, 0);
        step(0, '0, 0, 0, 1);
        check("mrst_d0", s_read_data, 16'h55);
        step(0, '0, 0, 0, 1);
        check("mrst_d1", s_read_data, 16'h66);
        check("mrst_l1", s_read_last, 1);

        // Randomized traffic: write-heavy then read-heavy phases.
        for (int n = 0; n < 800; n++) begin
            int rd_pct;
            rd_pct = (n < 400) ? 30 : 70;
            step($urandom_range(0, 99) < 65,
                 16'($urandom_range(0, 65535)),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 99) < rd_pct,
                 $urandom_range(0, 299) != 0);
        end

        step(0, '0, 0, 0, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/synchronous_packet_fifo.md
Name: synchronous_packet_fifo

Overview:
Next-generation synchronous FIFO for the switch datapath, packet-aware with store-and-forward semantics. A packet is only visible to the reader after its last word is committed. The writer can discard a partial packet, and a packet that overflows is dropped automatically. Adds almost-full/almost-empty thresholds, occupancy and packet counts, and overflow/underflow pulses; keeps standard and first-word-fall-through read modes.

Parameters:
DATA_WIDTH, 16, payload width in bits
DATA_DEPTH, 4096, words of storage; power of 2, ≥4
FIRST_WORD_FALL_THROUGH, 0, 0 = standard read (1-cycle latency), 1 = FWFT
ALMOST_FULL_THRESHOLD, DATA_DEPTH-4, almost_full asserted when used_count ≥ this
ALMOST_EMPTY_THRESHOLD, 4, almost_empty asserted when committed_count ≤ this

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous, active-low reset
write_enable  input  1  write write_data this cycle
write_data  input  DATA_WIDTH  write word
write_last  input  1  qualifies write_enable; word is packet end, commit packet
write_drop  input  1  discard the packet currently being written
read_enable  input  1  pop request
read_data  output  DATA_WIDTH  read word
read_data_valid  output  1  read_data holds a valid word
read_last  output  1  read_data is the last word of its packet
full  output  1  no free word (tentative write pointer vs read pointer)
empty  output  1  no committed word available
almost_full  output  1  per threshold
almost_empty  output  1  per threshold
used_count  output  $clog2(DATA_DEPTH)+1  words held, committed plus uncommitted
packet_count  output  $clog2(DATA_DEPTH)+1  committed packets not yet fully read
overflow  output  1  one-cycle pulse: write attempted while full
underflow  output  1  one-cycle pulse: read attempted while empty

Behaviour:
- Reset: pointers, counts, and all outputs 0, except empty=1 and almost_empty=1. Reset mid-packet discards everything, including uncommitted words.
- Storage: DATA_WIDTH+1 bits per word (data plus last flag). Three pointers: read, committed write, tentative write. Each pointer carries one extra wrap bit, so full and empty are unambiguous at wrap-around.
- Write:
  - write_enable && !full: store word at the tentative pointer, then advance it.
  - Adding write_last: the committed pointer moves to the new tentative pointer and packet_count increments, on the same edge.
- Write while full: word ignored, overflow=1 for one cycle, and the in-progress packet is marked poisoned. When a poisoned packet's write_last arrives, the packet is dropped instead of committed.
- write_drop: tentative pointer reverts to the committed pointer and poison clears. If asserted with write_enable, drop wins and the word is discarded.
- Visibility: empty and committed_count reflect only committed words. A write_last commit becomes visible on the following cycle.
- Standard read mode: read_enable && !empty reads the head. read_data, read_last, and read_data_valid=1 appear on the next cycle; read_data_valid is low otherwise, and read_data holds its last value.
- FWFT read mode: read_data/read_last show the head combinationally from a prefetch register; read_data_valid = !empty. read_enable && read_data_valid pops.
- Popping a word with last=1 decrements packet_count.
- read_enable && empty: no pop, underflow=1 for one cycle.
- Simultaneous read and write: both proceed. At full, a read does not free space for a write in the same cycle.
- Counts: packet_count may increment and decrement in the same cycle, giving a net change of 0.
- used_count = tentative − read (modulo wrap bit). committed_count (internal) = committed − read.

Optional Feature:
SYNCHRONOUS_PACKET_FIFO_STATS_EN
- Defined: adds output dropped_packet_count, 16 bits, saturating at 0xFFFF, reset to 0. It increments on each write_drop while the tentative and committed pointers differ, and on each poisoned-packet auto-drop.
- Undefined: port and logic absent. Drop behaviour is otherwise identical.

Test Plan:
All scenarios use DEPTH=8, WIDTH=16, standard mode unless noted.
- Commit visibility: write 0xA1, 0xA2, 0xA3 (last on 0xA3) → empty stays 1 until the cycle after 0xA3. Then packet_count=1, used_count=3. Three reads return A1, A2, A3 with read_last=1 only on A3, and packet_count=0.
- Drop: write 0x10, 0x11, then assert write_drop → used_count returns to 0, empty=1, stats counter=1. Next packet 0x20 (last) reads back 0x20.
- Overflow poison: write 9 words with last on the 9th → overflow pulses once at the 9th write, the packet is auto-dropped, used_count=0, empty=1.
- Wrap-around: 5 packets of 3 words, each read fully before the next is written → data intact across the pointer wrap; full is never asserted.
- FWFT=1: write 0xBEEF (last) → read_data=0xBEEF with read_data_valid=1 one cycle after the commit, before any read_enable. A pop gives read_data_valid=0. A read while empty pulses underflow.
- Reset mid-packet: write 0x01, 0x02 (no last), pulse reset_n low for 1 cycle → all counts 0, empty=1, and a subsequent packet reads back correctly.
